// File: rtl/iob_fifo_burst_arb.sv
// Round-robin burst arbiter feeding one shared FIFO write port.
// A requester is granted only when the FIFO has room for its whole burst.
module iob_fifo_burst_arb #(
    parameter int unsigned N_REQ        = 2,
    parameter int unsigned W_DATA_W     = 32,
    parameter int unsigned BURST_LEN    = 4,
    parameter int unsigned OCC_W        = 32,
    parameter int unsigned FIFO_CAP     = 16,
    parameter int unsigned OCC_PER_WORD = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          valid,
    input  logic [N_REQ*W_DATA_W-1:0] data_in,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          ready,
    output logic [N_REQ-1:0]          done,
    output logic                      busy,
    output logic [W_DATA_W-1:0]       fifo_data_out,
    output logic                      fifo_write_en,
    input  logic                      fifo_full,
    input  logic [OCC_W-1:0]          fifo_ocupancy
);
    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned CMP_W  = ((OCC_W > 32) ? OCC_W : 32) + 2;

    localparam logic [CMP_W-1:0]  NEED      = CMP_W'(BURST_LEN * OCC_PER_WORD);
    localparam logic [CMP_W-1:0]  CAP       = CMP_W'(FIFO_CAP);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(N_REQ - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_last;
    logic [BEAT_W-1:0]    r_beat;
    logic [N_REQ-1:0]     r_gnt;
    logic [N_REQ-1:0]     r_done;

    logic [W_DATA_W-1:0]  w_words [N_REQ];
    logic [CMP_W-1:0]     w_occ;
    logic                 w_room;
    logic                 w_found;
    logic [IDX_W-1:0]     w_win;
    logic                 w_grant;
    logic                 w_last_acc;

    // Unpack the flattened requester data bus.
    always_comb begin
        for (int i = 0; i < int'(N_REQ); i++) begin
            w_words[i] = data_in[i*W_DATA_W +: W_DATA_W];
        end
    end

    // Room check; an occupancy above capacity counts as no room.
    assign w_occ  = CMP_W'(fifo_ocupancy);
    assign w_room = (w_occ <= CAP) && ((CAP - w_occ) >= NEED);

    // Round-robin search starting just after the previous winner.
    always_comb begin : find_winner
        int unsigned          idx;
        logic [IDX_W-1:0]     sel;
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        sel     = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = 32'(r_last) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            sel = IDX_W'(idx);
            if (!w_found && req[sel]) begin
                w_found = 1'b1;
                w_win   = sel;
            end
        end
    end

    assign w_grant    = (r_state == S_IDLE) && en && w_found && w_room;
    assign w_last_acc = fifo_write_en && (r_beat == LAST_BEAT);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: only the final accepted beat ends a burst.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant)    w_state_nxt = S_BURST;
            S_BURST: if (w_last_acc) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Write-port steering toward the granted requester.
    always_comb begin
        ready         = '0;
        fifo_write_en = 1'b0;
        fifo_data_out = '0;
        if (r_state == S_BURST) begin
            ready[r_last] = ~fifo_full;
            fifo_write_en = valid[r_last] & ~fifo_full;
            fifo_data_out = w_words[r_last];
        end
    end

    // Grant, beat counter, winner history and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= IDX_MAX;
            r_beat <= '0;
            r_gnt  <= '0;
            r_done <= '0;
        end else begin
            r_done <= '0;
            if (w_grant) begin
                r_last <= w_win;
                r_beat <= '0;
                r_gnt  <= N_REQ'(1) << w_win;
            end else if ((r_state == S_BURST) && fifo_write_en) begin
                if (r_beat == LAST_BEAT) begin
                    r_beat         <= '0;
                    r_gnt          <= '0;
                    r_done[r_last] <= 1'b1;
                end else begin
                    r_beat <= r_beat + BEAT_W'(1);
                end
            end
        end
    end

    assign gnt  = r_gnt;
    assign done = r_done;
    assign busy = (r_state == S_BURST);

endmodule

// File: tb/tb_iob_fifo_burst_arb.sv
// Directed bench for iob_fifo_burst_arb driving a behavioural 32->8 FIFO.
// Requester r sends word k as bytes r*0x40 + 4k .. +3, little-endian.
module tb_iob_fifo_burst_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  req;
    logic [1:0]  valid;
    logic [63:0] data_in;
    logic [1:0]  gnt;
    logic [1:0]  ready;
    logic [1:0]  done;
    logic        busy;
    logic [31:0] fifo_data_out;
    logic        fifo_write_en;
    logic        fifo_full;
    logic [31:0] fifo_ocupancy = '0;

    logic        rd;
    logic        force_full;
    logic [7:0]  fq[$];
    logic [7:0]  rdq[$];
    logic [1:0]  gnt_log[$];
    logic [1:0]  gnt_q = '0;
    logic [7:0]  src_idx [2] = '{8'd0, 8'd0};
    int          wr_cnt = 0;
    int          done_cnt0 = 0;
    int          done_cnt1 = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [7:0]  t3_base [3] = '{8'h10, 8'h50, 8'h20};

    iob_fifo_burst_arb dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .req           (req),
        .valid         (valid),
        .data_in       (data_in),
        .gnt           (gnt),
        .ready         (ready),
        .done          (done),
        .busy          (busy),
        .fifo_data_out (fifo_data_out),
        .fifo_write_en (fifo_write_en),
        .fifo_full     (fifo_full),
        .fifo_ocupancy (fifo_ocupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_word(input int r, input logic [7:0] k);
        logic [7:0] b;
        b = 8'(r * 64) + {k[5:0], 2'b00};
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            data_in[32*i +: 32] = mk_word(i, src_idx[i]);
        end
    end

    // 16-byte FIFO: one word in, one byte out per cycle.
    assign fifo_full = (fifo_ocupancy > 32'd12) || force_full;

    always @(posedge clk) begin
        if (rd && fq.size() > 0) rdq.push_back(fq.pop_front());
        if (fifo_write_en) begin
            wr_cnt++;
            for (int j = 0; j < 4; j++) fq.push_back(fifo_data_out[8*j +: 8]);
        end
        fifo_ocupancy <= 32'(fq.size());
        if (done[0]) done_cnt0++;
        if (done[1]) done_cnt1++;
        if (gnt != 2'b00 && gnt_q == 2'b00) gnt_log.push_back(gnt);
        gnt_q = gnt;
        for (int i = 0; i < 2; i++) begin
            if (fifo_write_en && gnt[i]) src_idx[i] <= src_idx[i] + 8'd1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int n;
        n = 0;
        while (busy !== lvl && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(busy), 64'(lvl));
    endtask

    task automatic drain_chk(input logic [7:0] base, input int n, input string tag);
        int         k;
        logic [7:0] e;
        k = 0;
        rdq.delete();
        rd = 1'b1;
        while (rdq.size() < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        rd = 1'b0;
        chk({tag, "_cnt"}, 64'(rdq.size()), 64'(n));
        for (int i = 0; i < n && i < rdq.size(); i++) begin
            e = base + 8'(i);
            chk(tag, 64'(rdq[i]), 64'(e));
        end
    endtask

    initial begin
        int         w0;
        int         d0;
        int         bc;
        int         k;
        logic       ph;
        logic       seen;
        logic [7:0] e;

        rst = 1'b1; en = 1'b0; req = 2'b00; valid = 2'b00; rd = 1'b0; force_full = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_gnt",   64'(gnt), 64'(0));
        chk("rst_busy",  64'(busy), 64'(0));
        chk("rst_ready", 64'(ready), 64'(0));
        chk("rst_done",  64'(done), 64'(0));
        chk("rst_fwe",   64'(fifo_write_en), 64'(0));
        chk("rst_fdo",   64'(fifo_data_out), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        // Empty FIFO, both requesting: requester 0 wins first.
        en = 1'b1; req = 2'b11; valid = 2'b11; w0 = wr_cnt;
        wait_busy(1'b1, "t1_grant_wait");
        chk("t1_gnt", 64'(gnt), 64'(2'b01));
        wait_busy(1'b0, "t1_end_wait");
        req = 2'b00;
        chk("t1_done", 64'(done), 64'(2'b01));
        chk("t1_writes", 64'(wr_cnt - w0), 64'(4));
        chk("t1_occ", 64'(fifo_ocupancy), 64'(16));

        // Full FIFO blocks the grant until fully drained.
        req = 2'b10;
        repeat (4) @(negedge clk);
        chk("t2_blocked", 64'(gnt), 64'(0));
        chk("t1_done_once", 64'(done_cnt0), 64'(1));
        drain_chk(8'h00, 16, "t1_data");
        chk("t2_occ0", 64'(fifo_ocupancy), 64'(0));
        chk("t2_gnt_eval", 64'(gnt), 64'(0));
        @(negedge clk);
        chk("t2_gnt", 64'(gnt), 64'(2'b10));
        wait_busy(1'b0, "t2_end_wait");
        req = 2'b00;
        chk("t2_done1", 64'(done_cnt1 + (done[1] ? 1 : 0)), 64'(1));
        drain_chk(8'h40, 16, "t2_data");

        // Back-to-back requests with continuous draining alternate grants.
        d0 = done_cnt0 + done_cnt1;
        gnt_log.delete(); rdq.delete();
        rd = 1'b1; req = 2'b11; valid = 2'b11;
        k = 0;
        while (done_cnt0 + done_cnt1 < d0 + 3 && k < 600) begin
            @(negedge clk);
            k++;
        end
        req = 2'b00;
        k = 0;
        while (rdq.size() < 48 && k < 200) begin
            @(negedge clk);
            k++;
        end
        rd = 1'b0;
        chk("t3_bursts", 64'(done_cnt0 + done_cnt1 - d0), 64'(3));
        chk("t3_nlog", 64'(gnt_log.size()), 64'(3));
        if (gnt_log.size() >= 3) begin
            chk("t3_g0", 64'(gnt_log[0]), 64'(2'b01));
            chk("t3_g1", 64'(gnt_log[1]), 64'(2'b10));
            chk("t3_g2", 64'(gnt_log[2]), 64'(2'b01));
        end
        chk("t3_nbytes", 64'(rdq.size()), 64'(48));
        for (int i = 0; i < 48 && i < rdq.size(); i++) begin
            e = t3_base[i/16] + 8'(i % 16);
            chk("t3_data", 64'(rdq[i]), 64'(e));
        end

        // Requester 0 with valid toggling 1,0,1,0...
        req = 2'b01; valid = 2'b00; w0 = wr_cnt; d0 = done_cnt0;
        ph = 1'b1; bc = 0; seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1'b1;
                bc++;
                valid[0] = ph;
                ph = ~ph;
            end else if (seen) begin
                break;
            end
        end
        req = 2'b00; valid = 2'b00;
        chk("t4_cycles", 64'(bc), 64'(7));
        chk("t4_writes", 64'(wr_cnt - w0), 64'(4));
        repeat (3) @(negedge clk);
        chk("t4_done_once", 64'(done_cnt0 - d0), 64'(1));
        drain_chk(8'h30, 16, "t4_data");

        // en low blocks grants; dropping en/req mid-burst does not cut it short.
        en = 1'b0; req = 2'b11; valid = 2'b11;
        repeat (6) @(negedge clk);
        chk("t5_en0_gnt", 64'(gnt), 64'(0));
        chk("t5_en0_busy", 64'(busy), 64'(0));
        en = 1'b1;
        wait_busy(1'b1, "t5_grant_wait");
        chk("t5_gnt", 64'(gnt), 64'(2'b10));
        en = 1'b0; req = 2'b00; force_full = 1'b1;
        #1;
        chk("t5_full_ready", 64'(ready), 64'(0));
        chk("t5_full_fwe", 64'(fifo_write_en), 64'(0));
        w0 = wr_cnt;
        repeat (3) @(negedge clk);
        chk("t5_stall_writes", 64'(wr_cnt - w0), 64'(0));
        chk("t5_stall_busy", 64'(busy), 64'(1));
        force_full = 1'b0;
        #1;
        chk("t5_ready", 64'(ready), 64'(2'b10));
        chk("t5_fwe", 64'(fifo_write_en), 64'(1));
        wait_busy(1'b0, "t5_end_wait");
        chk("t5_writes", 64'(wr_cnt - w0), 64'(4));
        chk("t5_done", 64'(done), 64'(2'b10));
        drain_chk(8'h60, 16, "t5_data");

        // Reset mid-burst abandons it; requester 0 regains first priority.
        en = 1'b1; req = 2'b11; valid = 2'b11; w0 = wr_cnt; d0 = done_cnt0;
        k = 0;
        while (wr_cnt < w0 + 2 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("t6_mid_gnt", 64'(gnt), 64'(2'b01));
        rst = 1'b0;
        #1;
        chk("t6_rst_gnt", 64'(gnt), 64'(0));
        chk("t6_rst_busy", 64'(busy), 64'(0));
        chk("t6_rst_fwe", 64'(fifo_write_en), 64'(0));
        chk("t6_rst_ready", 64'(ready), 64'(0));
        repeat (2) @(negedge clk);
        chk("t6_no_done", 64'(done_cnt0 - d0), 64'(0));
        rst = 1'b1; rd = 1'b1;
        wait_busy(1'b1, "t6_regrant_wait");
        chk("t6_regrant", 64'(gnt), 64'(2'b01));
        wait_busy(1'b0, "t6_end_wait");
        chk("t6_done", 64'(done), 64'(2'b01));
        rd = 1'b0; req = 2'b00; valid = 2'b00;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
